// File: rtl/mimo_frame_loader.sv
// mimo_frame_loader: packs a serial W_l-bit word stream into channel-row bursts and paced data vectors for the MIMO decoder.
// Define MIMO_LOADER_VCOUNT_EN to count issued data vectors on vec_count; otherwise vec_count is tied to 0.
module mimo_frame_loader #(
    parameter int W_l           = 15,
    parameter int DATA_INTERVAL = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W_l-1:0]   s_data,
    input  logic             s_chan,
    output logic             dec_flag,
    output logic [8*W_l-1:0] dec_data,
    output logic             dec_new,
    output logic             busy,
    output logic             err,
    output logic [15:0]      vec_count
);
    typedef enum logic [1:0] {ST_IDLE, ST_CH_ISSUE, ST_HOLD} state_t;

    state_t               state_q, state_d;
    logic [31:0][W_l-1:0] ch_q, ch_d;
    logic [7:0][W_l-1:0]  sh_q, sh_d;
    logic [8*W_l-1:0]     dec_data_q, dec_data_d;
    logic [7:0]           icnt_q, icnt_d;
    logic [4:0]           cnt_q, cnt_d, idx;
    logic [1:0]           row;
    logic                 tag_q, tag_d, ch_pend_q, ch_pend_d, sh_full_q, sh_full_d;
    logic                 ch_loaded_q, ch_loaded_d, s_ready_q, s_ready_d;
    logic                 dec_flag_q, dec_flag_d, dec_new_q, dec_new_d, err_q, err_d;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        sh_d        = sh_q;
        dec_data_d  = dec_data_q;
        icnt_d      = icnt_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        ch_pend_d   = ch_pend_q;
        sh_full_d   = sh_full_q;
        ch_loaded_d = ch_loaded_q;
        dec_flag_d  = dec_flag_q;
        dec_new_d   = 1'b0;
        err_d       = err_q;
        idx         = cnt_q;
        row         = (state_q == ST_CH_ISSUE) ? icnt_q[1:0] + 2'd1 : 2'd0;
        if (s_valid && s_ready_q) begin
            // A tag change abandons the partial group and restarts at slot 0
            idx   = (cnt_q != 5'd0 && s_chan != tag_q) ? 5'd0 : cnt_q;
            err_d = err_q | (cnt_q != 5'd0 && s_chan != tag_q);
            tag_d = s_chan;
            if (s_chan) begin
                ch_d[idx] = s_data;
                cnt_d     = idx + 5'd1;
                ch_pend_d = (idx == 5'd31);
            end else begin
                sh_d[idx[2:0]] = s_data;
                cnt_d          = (idx == 5'd7) ? 5'd0 : idx + 5'd1;
                sh_full_d      = (idx == 5'd7) && ch_loaded_q;
                err_d          = err_d | ((idx == 5'd7) && !ch_loaded_q);
            end
        end
        if (state_q == ST_CH_ISSUE) begin
            if (icnt_q == 8'd3) begin
                state_d     = ST_IDLE;
                dec_flag_d  = 1'b0;
                dec_data_d  = '0;
                ch_pend_d   = 1'b0;
                ch_loaded_d = 1'b1;
            end else begin
                icnt_d     = icnt_q + 8'd1;
                dec_data_d = ch_q[{row, 3'b000} +: 8];
            end
        end else if (state_q == ST_HOLD && icnt_q != 8'd0) begin
            icnt_d = icnt_q - 8'd1;
        end else if (ch_pend_q) begin
            state_d    = ST_CH_ISSUE;
            icnt_d     = 8'd0;
            dec_flag_d = 1'b1;
            dec_data_d = ch_q[{row, 3'b000} +: 8];
        end else if (sh_full_q) begin
            state_d    = ST_HOLD;
            icnt_d     = 8'(DATA_INTERVAL - 1);
            dec_data_d = sh_q;
            dec_new_d  = 1'b1;
            sh_full_d  = 1'b0;
        end else begin
            state_d = ST_IDLE;
        end
        s_ready_d = !sh_full_d && !ch_pend_d && (state_d != ST_CH_ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            sh_q        <= '0;
            dec_data_q  <= '0;
            icnt_q      <= '0;
            cnt_q       <= '0;
            tag_q       <= 1'b0;
            ch_pend_q   <= 1'b0;
            sh_full_q   <= 1'b0;
            ch_loaded_q <= 1'b0;
            s_ready_q   <= 1'b0;
            dec_flag_q  <= 1'b1;
            dec_new_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            sh_q        <= sh_d;
            dec_data_q  <= dec_data_d;
            icnt_q      <= icnt_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            ch_pend_q   <= ch_pend_d;
            sh_full_q   <= sh_full_d;
            ch_loaded_q <= ch_loaded_d;
            s_ready_q   <= s_ready_d;
            dec_flag_q  <= dec_flag_d;
            dec_new_q   <= dec_new_d;
            err_q       <= err_d;
        end
    end

`ifdef MIMO_LOADER_VCOUNT_EN
    logic [15:0] vcnt_q, vcnt_d;

    always_comb vcnt_d = (state_q == ST_CH_ISSUE && icnt_q == 8'd3) ? 16'd0 : vcnt_q + 16'(dec_new_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vcnt_q <= '0;
        else vcnt_q <= vcnt_d;
    end

    assign vec_count = vcnt_q;
`else
    assign vec_count = '0;
`endif

    assign s_ready  = s_ready_q;
    assign dec_flag = dec_flag_q;
    assign dec_data = dec_data_q;
    assign dec_new  = dec_new_q;
    assign err      = err_q;
    assign busy     = (cnt_q != 5'd0) || (state_q != ST_IDLE) || ch_pend_q || sh_full_q;
endmodule

// File: doc/mimo_frame_loader.md
# mimo_frame_loader

Upstream input stage of the 4-best 8-PSK MIMO decoder. It accepts a serial stream of W_l-bit words over a valid/ready handshake, assembles them into the 8-word parallel bus the decoder consumes, and drives the decoder's channel/data select flag. Channel loads (4 upper-triangular R rows) are issued as a 4-cycle burst. Received vectors are issued at a fixed decoder cadence of DATA_INTERVAL cycles, with double buffering so the stream can run ahead by one vector.

## Interface
- W_l, 15: word width, two's complement
- DATA_INTERVAL, 38: cycles each received vector is held on dec_data; legal range 2..255

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- s_valid  in  1  stream word valid
- s_ready  out  1  loader can accept a word
- s_data  in  W_l  stream word
- s_chan  in  1  word tag: 1 = channel word, 0 = data word
- dec_flag  out  1  to decoder flagChannelorData: 1 = channel row, 0 = data
- dec_data  out  8*W_l  to decoder InData; slot s occupies bits [(s+1)*W_l-1 : s*W_l]
- dec_new  out  1  one-cycle pulse on the first cycle of a newly issued data vector
- busy  out  1  a group is partially collected or an issue is in progress
- err  out  1  sticky protocol error
- vec_count  out  16  data vectors issued since last channel burst (see Configuration)

## Operation
- A word transfers when s_valid && s_ready.
- Words are grouped by tag:
  - A channel group is 32 words; word k goes to row k/8, slot k%8.
  - A data group is 8 words (y0r, y0i, y1r, y1i, …); word k goes to slot k.
- Tag change mid-group: the partial group is discarded, err is set, and the new word starts a fresh group of its own tag.
- A data group completed before any channel burst has been issued since reset is discarded, and err is set.
- FSM states and transitions:
  - IDLE: no group in progress.
  - COLLECT: gathering a group.
  - CH_ISSUE: 4 cycles. dec_flag=1 and dec_data = row 0, 1, 2, 3 on consecutive cycles.
  - HOLD: dec_flag=0, current vector on dec_data, interval counter running.
- After CH_ISSUE: dec_flag returns to 0 and dec_data shows zero until the first data vector issues. vec_count clears to 0.
- Data buffers: an active buffer (on dec_data) and a shadow buffer (collecting).
  - On HOLD expiry with the shadow full, the shadow moves to active on the next cycle and dec_new pulses.
  - On HOLD expiry with the shadow not full, dec_data keeps its last value and dec_flag stays 0. The next vector issues the cycle after it completes.
- A completed channel group waits until the current HOLD interval expires, then CH_ISSUE runs. A pending full shadow vector issues after CH_ISSUE.
- s_ready is deasserted when:
  - the shadow buffer is full, or
  - a completed channel group awaits issue, or
  - during CH_ISSUE.
- No arithmetic is performed on words; they pass bit-exact.

## Timing
- Reset values: s_ready=0, dec_flag=1, dec_data=0, dec_new=0, busy=0, err=0, vec_count=0. Internal FSM=IDLE; all buffers and counters cleared.
- s_ready rises on the first clock edge after rst deasserts.
- Channel latency: the 32nd accepted word at edge N gives row 0 on dec_data/dec_flag=1 after edge N+1, then rows 1–3 after edges N+2..N+4. dec_flag=0 after edge N+5.
- Data latency: with HOLD idle, the 8th word at edge N issues after edge N+1.
- Back-to-back vectors change dec_data exactly every DATA_INTERVAL cycles.
- s_ready is registered; it may drop only in the cycle after the word that fills a buffer.
- Reset mid-operation discards all partial and pending groups immediately; there is no output glitch beyond the reset values.
- err clears only on reset.

## Configuration
- MIMO_LOADER_VCOUNT_EN defined: vec_count increments (wrapping at 65535→0) on each dec_new pulse and clears at the end of CH_ISSUE.
- Not defined: vec_count is tied to 0 and the counter logic is removed; all other behaviour is identical.

## Test plan
- Reset check: hold rst=0 for 10 cycles → all outputs at reset values; release → s_ready=1 on the next edge.
- Channel load: stream 32 words with s_chan=1, word k = k+1 → four consecutive cycles with dec_flag=1 and row r slot s = 8r+s+1, then dec_flag=0 and dec_data=0.
- Data cadence: after the channel load, stream 3 data groups at full rate with DATA_INTERVAL=38 → dec_data changes every 38 cycles, dec_new pulses 3 times, s_ready low while the shadow is full, vec_count=3.
- Tag violation: send 5 data words then 1 channel word → err=1, no vector issued, and the channel group restarts at word 0.
- Data before channel: send 8 data words straight after reset → err=1, dec_flag stays 1 and dec_data=0.
- Mid-hold channel update: complete a channel group 10 cycles into a HOLD → CH_ISSUE begins exactly at HOLD expiry, and vec_count resets to 0 afterwards.
